// File: rtl/imm_encoder_pkg.sv
// Purpose: shared definitions for the immediate encoder. The format codes are the
//          same ones the immediate extender decodes, so both ends agree on in_ctrl.
// Contents: width constants, immediate format codes, stage-1 request payload struct.
package imm_encoder_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 3;

  localparam logic [CTRL_W-1:0] IMM_I  = 3'b000;  // I-type, sign-extended
  localparam logic [CTRL_W-1:0] IMM_S  = 3'b001;
  localparam logic [CTRL_W-1:0] IMM_B  = 3'b010;
  localparam logic [CTRL_W-1:0] IMM_J  = 3'b011;
  localparam logic [CTRL_W-1:0] IMM_U  = 3'b100;
  localparam logic [CTRL_W-1:0] IMM_IZ = 3'b101;  // I-type, zero-extended

  typedef struct packed {
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   base;
  } imm_req_t;

endpackage

// File: rtl/imm_encoder_if.sv
// Purpose: request/response handshake bundle for the immediate encoder.
// Signals: in_valid/in_ready/in_imm/in_ctrl/in_base (request),
//          out_valid/out_ready/out_instr/out_err (result).
// Modports: master = producer of requests and consumer of results, slave = encoder.
interface imm_encoder_if;
  import imm_encoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [XLEN-1:0]   in_base;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_instr;
  logic              out_err;

  modport master (
    output in_valid, in_imm, in_ctrl, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_ctrl, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

endinterface

// File: rtl/imm_range_check.sv
// Purpose: combinational check that an immediate survives encode/extend unchanged
//          for the selected format.
// Ports: imm (immediate), ctrl (format code), err_c (1 = not representable or
//        illegal format code).
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [XLEN-1:0]   imm,
  input  logic [CTRL_W-1:0] ctrl,
  output logic              err_c
);

  logic same_31_11_c;
  logic same_31_12_c;
  logic same_31_20_c;

  // Upper bits must be a pure sign extension of the top encodable bit.
  assign same_31_11_c = (&imm[31:11]) | ~(|imm[31:11]);
  assign same_31_12_c = (&imm[31:12]) | ~(|imm[31:12]);
  assign same_31_20_c = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    err_c = 1'b1;
    case (ctrl)
      IMM_I, IMM_S: err_c = ~same_31_11_c;
      IMM_B:        err_c = ~same_31_12_c | imm[0];
      IMM_J:        err_c = ~same_31_20_c | imm[0];
      IMM_U:        err_c = |imm[11:0];
      IMM_IZ:       err_c = |imm[31:12];
      default:      err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Purpose: packs a 32-bit immediate into the I/S/B/J/U field layout of an RV32
//          instruction, merging it into a base word. Two-stage valid/ready pipeline:
//          s1 captures the request and its range-check result, s2 holds the packed word.
// Ports: clk, rst (sync, active-high), bus (imm_encoder_if.slave handshake bundle),
//        err_count (saturating count of transferred results flagged out_err).
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] err_count
);

  logic             s1_v_q,     s1_v_d;
  imm_req_t         s1_req_q,   s1_req_d;
  logic             s1_err_q,   s1_err_d;
  logic             s2_v_q,     s2_v_d;
  logic [XLEN-1:0]  s2_instr_q, s2_instr_d;
  logic             s2_err_q,   s2_err_d;
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

  logic             rc_err_c;
  logic             s2_adv_c;
  logic             s1_adv_c;
  logic             accept_c;
  logic             emit_c;
  logic [XLEN-1:0]  pack_c;

  imm_range_check u_range_check (
    .imm   (bus.in_imm),
    .ctrl  (bus.in_ctrl),
    .err_c (rc_err_c)
  );

  // Pipeline advance conditions; s1 can refill in the same cycle s2 empties.
  assign s2_adv_c = ~s2_v_q | bus.out_ready;
  assign s1_adv_c = s2_adv_c | ~s1_v_q;
  assign accept_c = bus.in_valid & s1_adv_c;
  assign emit_c   = s2_v_q & bus.out_ready;

  // Field packing from the s1 request; untouched bits come from the base word.
  always_comb begin
    pack_c = s1_req_q.base;
    case (s1_req_q.ctrl)
      IMM_I, IMM_IZ: pack_c[31:20] = s1_req_q.imm[11:0];
      IMM_S: begin
        pack_c[31:25] = s1_req_q.imm[11:5];
        pack_c[11:7]  = s1_req_q.imm[4:0];
      end
      IMM_B: begin
        pack_c[31]    = s1_req_q.imm[12];
        pack_c[30:25] = s1_req_q.imm[10:5];
        pack_c[11:8]  = s1_req_q.imm[4:1];
        pack_c[7]     = s1_req_q.imm[11];
      end
      IMM_J: begin
        pack_c[31]    = s1_req_q.imm[20];
        pack_c[30:21] = s1_req_q.imm[10:1];
        pack_c[20]    = s1_req_q.imm[11];
        pack_c[19:12] = s1_req_q.imm[19:12];
      end
      IMM_U:   pack_c[31:12] = s1_req_q.imm[31:12];
      default: pack_c = s1_req_q.base;
    endcase
  end

  // Next-state for both stages and the error counter.
  always_comb begin
    s1_v_d     = s1_v_q;
    s1_req_d   = s1_req_q;
    s1_err_d   = s1_err_q;
    s2_v_d     = s2_v_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;

    if (s1_adv_c) begin
      s1_v_d = bus.in_valid;
    end
    if (accept_c) begin
      s1_req_d = '{imm: bus.in_imm, ctrl: bus.in_ctrl, base: bus.in_base};
      s1_err_d = rc_err_c;
    end

    if (s2_adv_c) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_instr_d = pack_c;
        s2_err_d   = s1_err_q;
      end
    end

    if (emit_c && s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_req_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_req_q   <= s1_req_d;
      s1_err_q   <= s1_err_d;
      s2_v_q     <= s2_v_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.in_ready  = s1_adv_c;
  assign bus.out_valid = s2_v_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_err   = s2_err_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized checks of the immediate encoder against hand-computed
// words and an independent immediate-extender model.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam int unsigned TB_CNT_W = 4;
  localparam int NRAND = 10000;

  logic clk;
  logic rst;
  logic [TB_CNT_W-1:0] err_count;
  int n_checks;
  int n_pass;

  imm_encoder_if bus ();

  imm_encoder #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors: imm, ctrl, base -> expected word and err.
  localparam logic [31:0] F_IMM  [10] = '{32'hFFFFFFFF, 32'h00000800, 32'hFFFFF800, 32'hFFFFFFFC,
                                          32'h00000003, 32'h00000800, 32'h00100000, 32'h12345001,
                                          32'h00000FFF, 32'h00000001};
  localparam logic [2:0]  F_CTRL [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6};
  localparam logic [31:0] F_BASE [10] = '{32'h00000013, 32'h00000013, 32'h00002023, 32'h00000063,
                                          32'h00000063, 32'h0000006F, 32'h0000006F, 32'h00000037,
                                          32'h00007013, 32'hDEADBEEF};
  localparam logic [31:0] F_EXP  [10] = '{32'hFFF00013, 32'h80000013, 32'h80002023, 32'hFE000EE3,
                                          32'h00000163, 32'h0010006F, 32'h8000006F, 32'h12345037,
                                          32'hFFF07013, 32'hDEADBEEF};
  localparam logic        F_ERR  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  ctrl;
    logic [31:0] base;
    logic        err;
  } exp_t;

  // Immediate extender: the decode side the encoder must round-trip with.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] c);
    case (c)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      3'd4:    return {w[31:12], 12'h000};
      3'd5:    return {20'h00000, w[31:20]};
      default: return w;
    endcase
  endfunction

  function automatic logic representable(input logic [31:0] v, input logic [2:0] c);
    case (c)
      3'd0, 3'd1: return {{20{v[11]}}, v[11:0]} == v;
      3'd2:       return {{19{v[12]}}, v[12:1], 1'b0} == v;
      3'd3:       return {{11{v[20]}}, v[20:1], 1'b0} == v;
      3'd4:       return v[11:0] == 12'h000;
      3'd5:       return v[31:12] == 20'h00000;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [2:0] c);
    case (c)
      3'd0, 3'd5: return 32'hFFF00000;
      3'd1, 3'd2: return 32'hFE000F80;
      3'd3, 3'd4: return 32'hFFFFF000;
      default:    return 32'h00000000;
    endcase
  endfunction

  function automatic exp_t new_vec();
    exp_t e;
    logic [31:0] raw;
    int r;
    r = int'($urandom_range(0, 15));
    e.ctrl = (r < 14) ? 3'(r % 6) : 3'(6 + (r & 1));
    raw = $urandom;
    e.base = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      case (e.ctrl)
        3'd0, 3'd1: e.imm = {{20{raw[11]}}, raw[11:0]};
        3'd2:       e.imm = {{19{raw[12]}}, raw[12:1], 1'b0};
        3'd3:       e.imm = {{11{raw[20]}}, raw[20:1], 1'b0};
        3'd4:       e.imm = {raw[31:12], 12'h000};
        3'd5:       e.imm = {20'h00000, raw[11:0]};
        default:    e.imm = raw;
      endcase
    end else begin
      e.imm = raw;
    end
    e.err = ~representable(e.imm, e.ctrl);
    return e;
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_ctrl   = '0;
    bus.in_base   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_instr !== 32'h0) $display("FAIL reset out_instr: got %h exp 0", bus.out_instr); else n_pass++;
    n_checks++; if (bus.out_err !== 1'b0) $display("FAIL reset out_err: got %b exp 0", bus.out_err); else n_pass++;
    n_checks++; if (err_count !== '0) $display("FAIL reset err_count: got %0d exp 0", err_count); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b exp 1", bus.in_ready); else n_pass++;
  endtask

  // One request at a time: checks latency, packed word and err for each format.
  task automatic test_formats();
    int exp_errs;
    exp_errs = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_imm = F_IMM[k]; bus.in_ctrl = F_CTRL[k]; bus.in_base = F_BASE[k];
      bus.out_ready = 1'b1;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL fmt[%0d] in_ready: got %b exp 1", k, bus.in_ready); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fmt[%0d] early out_valid: got %b exp 0", k, bus.out_valid); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL fmt[%0d] out_valid: got %b exp 1", k, bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_instr !== F_EXP[k]) $display("FAIL fmt[%0d] out_instr: got %h exp %h", k, bus.out_instr, F_EXP[k]); else n_pass++;
      n_checks++; if (bus.out_err !== F_ERR[k]) $display("FAIL fmt[%0d] out_err: got %b exp %b", k, bus.out_err, F_ERR[k]); else n_pass++;
      if (F_ERR[k]) exp_errs++;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fmt drained out_valid: got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (err_count !== TB_CNT_W'(exp_errs)) $display("FAIL fmt err_count: got %0d exp %0d", err_count, exp_errs); else n_pass++;
  endtask

  // Four requests on consecutive cycles come out on consecutive cycles.
  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (k < 4) begin
        bus.in_valid = 1'b1; bus.in_imm = F_IMM[k]; bus.in_ctrl = F_CTRL[k]; bus.in_base = F_BASE[k];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (k < 4) begin
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b[%0d] in_ready: got %b exp 1", k, bus.in_ready); else n_pass++;
      end
      if (k >= 2) begin
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b[%0d] out_valid: got %b exp 1", k, bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_instr !== F_EXP[k-2]) $display("FAIL b2b[%0d] out_instr: got %h exp %h", k, bus.out_instr, F_EXP[k-2]); else n_pass++;
      end
      @(posedge clk);
    end
  endtask

  // out_ready low for 4 cycles while 3 requests arrive; order and stability kept.
  task automatic test_backpressure();
    logic [31:0] ea, eb, ec;
    ea = 32'h00500013; eb = 32'hABCDE037; ec = 32'h7E000FA3;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_imm = 32'h00000005; bus.in_ctrl = IMM_I; bus.in_base = 32'h00000013;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp accept A in_ready: got %b exp 1", bus.in_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.in_imm = 32'hABCDE000; bus.in_ctrl = IMM_U; bus.in_base = 32'h00000037;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp accept B in_ready: got %b exp 1", bus.in_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.in_imm = 32'h000007FF; bus.in_ctrl = IMM_S; bus.in_base = 32'h00000023;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp full[%0d] in_ready: got %b exp 0", c, bus.in_ready); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp full[%0d] out_valid: got %b exp 1", c, bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_instr !== ea) $display("FAIL bp held[%0d] out_instr: got %h exp %h", c, bus.out_instr, ea); else n_pass++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp release in_ready: got %b exp 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_instr !== ea) $display("FAIL bp out A: got %h exp %h", bus.out_instr, ea); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== eb) $display("FAIL bp out B: got %b/%h exp 1/%h", bus.out_valid, bus.out_instr, eb); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== ec) $display("FAIL bp out C: got %b/%h exp 1/%h", bus.out_valid, bus.out_instr, ec); else n_pass++;
    n_checks++; if (bus.out_err !== 1'b0) $display("FAIL bp out C err: got %b exp 0", bus.out_err); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp drained out_valid: got %b exp 0", bus.out_valid); else n_pass++;
  endtask

  // Random stream with random stalls, scored against the extender model.
  task automatic test_random_roundtrip();
    exp_t q[$];
    exp_t cur, e;
    int sent, got, cycles;
    logic acc, xfer, o_err;
    logic [31:0] o_instr, m;
    sent = 0; got = 0; cycles = 0;
    cur = new_vec();
    while (got < NRAND && cycles < 40000) begin
      @(negedge clk);
      bus.in_valid = (sent < NRAND) && ($urandom_range(0, 7) != 0);
      bus.in_imm = cur.imm; bus.in_ctrl = cur.ctrl; bus.in_base = cur.base;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = bus.in_valid & bus.in_ready;
      xfer = bus.out_valid & bus.out_ready;
      o_instr = bus.out_instr;
      o_err = bus.out_err;
      @(posedge clk);
      cycles++;
      if (xfer) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL rand unexpected output: got %h exp none", o_instr);
        end else begin
          n_pass++;
          e = q.pop_front();
          m = field_mask(e.ctrl);
          n_checks++; if (o_err !== e.err) $display("FAIL rand[%0d] err: got %b exp %b (imm %h ctrl %0d)", got, o_err, e.err, e.imm, e.ctrl); else n_pass++;
          n_checks++; if ((o_instr & ~m) !== (e.base & ~m)) $display("FAIL rand[%0d] passthrough: got %h exp %h", got, o_instr & ~m, e.base & ~m); else n_pass++;
          if (!e.err) begin
            n_checks++; if (extend(o_instr, e.ctrl) !== e.imm) $display("FAIL rand[%0d] roundtrip: got %h exp %h ctrl %0d", got, extend(o_instr, e.ctrl), e.imm, e.ctrl); else n_pass++;
          end
        end
        got++;
      end
      if (acc) begin
        q.push_back(cur);
        sent++;
        cur = new_vec();
      end
    end
    n_checks++;
    if (got < NRAND) $display("FAIL rand timeout: got %0d results exp %0d", got, NRAND); else n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // Reset with two words held in the pipeline: nothing may emerge afterwards.
  task automatic test_reset_in_flight();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_imm = 32'h00000010; bus.in_ctrl = IMM_I; bus.in_base = 32'h00000013;
    @(posedge clk);
    @(negedge clk);
    bus.in_imm = 32'h00000020;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rif in_ready: got %b exp 1", bus.in_ready); else n_pass++;
    n_checks++; if (err_count !== '0) $display("FAIL rif err_count: got %0d exp 0", err_count); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rif[%0d] out_valid: got %b exp 0", c, bus.out_valid); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  // Stream illegal-format requests until the narrow error counter pins at max.
  task automatic test_err_saturate();
    int sends [3] = '{14, 1, 3};
    int exps  [3] = '{14, 15, 15};
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < sends[p]; k++) begin
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_imm = 32'h00000000; bus.in_ctrl = 3'b111; bus.in_base = 32'h0BADF00D;
        @(posedge clk);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++; if (err_count !== TB_CNT_W'(exps[p])) $display("FAIL sat[%0d] err_count: got %0d exp %0d", p, err_count, exps[p]); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    test_reset();
    test_formats();
    test_back_to_back();
    test_backpressure();
    test_random_roundtrip();
    test_reset_in_flight();
    test_err_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
